// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the command-master state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RDWAIT,
    ST_RESP
  } mst_state_e;

endpackage

// File: rtl/ahb_lite_cmd_master.sv
// Single-outstanding AHB-Lite master: one valid/ready command becomes one
// NONSEQ transfer. Read data and error status come back on a one-cycle
// response pulse. A data phase stuck on HREADY=0 is aborted after TIMEOUT cycles.
module ahb_lite_cmd_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  output logic              WORK,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  // One counter serves both the HREADY-low wait and the read latency;
  // it only has to reach TIMEOUT, and RD_LAT (<=3) always fits as TIMEOUT>=2.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RL      = CNT_W'(RD_LAT);

  mst_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata_q;

  // Command FSM; every bus and response output is a register written here.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      wdata_q   <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      HSEL      <= 1'b0;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HTRANS    <= HTRANS_IDLE;
      HWDATA    <= '0;
      WORK      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            // Capture the command so the requester may change it right away.
            HADDR     <= cmd_addr;
            HWRITE    <= cmd_write;
            wdata_q   <= cmd_wdata;
            HSEL      <= 1'b1;
            HTRANS    <= HTRANS_NONSEQ;
            cmd_ready <= 1'b0;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          HTRANS <= HTRANS_IDLE;
          WORK   <= 1'b1;
          HWDATA <= HWRITE ? wdata_q : '0;
          cnt    <= '0;
          state  <= ST_DATA;
        end
        ST_DATA: begin
          if (HREADY) begin
            HSEL   <= 1'b0;
            WORK   <= 1'b0;
            HWDATA <= '0;
            if (HRESP == HRESP_ERROR) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= ST_RESP;
            end else if (HWRITE) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
              state     <= ST_RESP;
            end else if (RD_LAT == 0) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= HRDATA;
              state     <= ST_RESP;
            end else begin
              cnt   <= CNT_W'(1);
              state <= ST_RDWAIT;
            end
          end else if (cnt >= TO_LAST) begin
            // TIMEOUT consecutive low cycles including this one: abort.
            HSEL      <= 1'b0;
            WORK      <= 1'b0;
            HWDATA    <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_RESP;
          end else begin
            cnt <= (cnt == TO_MAX) ? cnt : cnt + CNT_W'(1);
          end
        end
        ST_RDWAIT: begin
          if (cnt >= RL) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= HRDATA;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master with a small timer-like slave:
// 0x000 enable (bit0), 0x004 free-running count, other addresses read 0xDEADBEEF,
// 0x3FFFFFFF answers ERROR. Expected responses go into a scoreboard queue.
module tb_ahb_lite_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [29:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        HSEL;
  logic [29:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        WORK;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  ahb_lite_cmd_master #(.ADDR_W(30), .DATA_W(32), .RD_LAT(1), .TIMEOUT(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .WORK(WORK), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  logic        en_r = 1'b0;
  logic [31:0] cnt_r = '0;
  logic [31:0] hrdata_r = '0;
  int          wcnt = 0;
  int          stall_cfg = 0;
  logic        stuck = 1'b0;

  assign HREADY = !stuck && (wcnt >= stall_cfg);
  assign HRESP  = WORK && HREADY && (HADDR == 30'h3FFFFFFF);
  assign HRDATA = hrdata_r;

  always @(posedge HCLK) begin
    wcnt <= WORK ? wcnt + 1 : 0;
    if (WORK && HREADY && HWRITE && HADDR == 30'h0) en_r <= HWDATA[0];
    if (WORK && HREADY && HWRITE && HADDR == 30'h4) cnt_r <= HWDATA;
    else if (en_r) cnt_r <= cnt_r + 1;
    if (WORK && HREADY && !HWRITE)
      hrdata_r <= (HADDR == 30'h0) ? {31'b0, en_r} :
                  (HADDR == 30'h4) ? cnt_r : 32'hDEADBEEF;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    int          tol;
    logic        err;
    int          lat;
    int          work;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: tracks each data phase, then scores the response against the queue head.
  int          run = 0;
  int          last_run = 0;
  logic [29:0] addr0 = '0;
  logic [31:0] wd0 = '0;
  logic        addr_bad = 1'b0;

  always @(negedge HCLK) begin
    if (WORK) begin
      if (run == 0) begin
        addr0 = HADDR; wd0 = HWDATA; addr_bad = 1'b0;
      end else if (HADDR !== addr0) addr_bad = 1'b1;
      run++;
    end else if (run != 0) begin
      last_run = run; run = 0;
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_rsp: got rsp_valid=1, want no response");
      end else begin
        exp_t e;
        logic [31:0] diff;
        e = sb.pop_front();
        diff = (rsp_rdata > e.rdata) ? rsp_rdata - e.rdata : e.rdata - rsp_rdata;
        nvec++;
        if (rsp_rdata === 32'bx || diff > 32'(e.tol)) begin
          nerr++;
          $display("FAIL rsp_rdata: got 0x%0h, want 0x%0h +/- %0d", rsp_rdata, e.rdata, e.tol);
        end
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("work_cycles", 32'(last_run), 32'(e.work));
        chk("hwdata", wd0, e.wdata);
        chk("haddr_stable", 32'(addr_bad), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic wr, input logic [29:0] a, input logic [31:0] d,
                       input logic push, input logic [31:0] xr, input int tol,
                       input logic xe, input int lat, input int work);
    int t = 0;
    exp_t e;
    @(negedge HCLK);
    while (!cmd_ready && t < 100) begin @(negedge HCLK); t++; end
    if (!cmd_ready) begin
      nvec++; nerr++;
      $display("FAIL cmd_ready_wait: got cmd_ready=0 for 100 cycles, want 1");
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    e.rdata = xr; e.tol = tol; e.err = xe; e.lat = lat; e.work = work;
    e.wdata = wr ? d : 32'h0; e.acc = cyc + 1;
    @(posedge HCLK);
    if (push) sb.push_back(e);
    #1;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = '1; cmd_wdata = 32'h5555AAAA;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge HCLK); t++; end
    if (sb.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL rsp_wait: got %0d responses pending after 200 cycles, want 0", sb.size());
      sb.delete();
    end
    @(negedge HCLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_hsel"},      32'(HSEL), 32'd0);
    chk({tag, "_haddr"},     32'(HADDR), 32'd0);
    chk({tag, "_hwrite"},    32'(HWRITE), 32'd0);
    chk({tag, "_htrans"},    32'(HTRANS), 32'd0);
    chk({tag, "_hwdata"},    HWDATA, 32'd0);
    chk({tag, "_work"},      32'(WORK), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk_reset_vals("reset");
    HRESETn = 1'b1;

    // 1: enable the timer; check address phase then write data phase
    issue(1'b1, 30'h0, 32'h1, 1'b1, 32'h0, 0, 1'b0, 3, 1);
    @(negedge HCLK);
    chk("addr_hsel", 32'(HSEL), 32'd1);
    chk("addr_htrans", 32'(HTRANS), 32'(2'b10));
    chk("addr_work", 32'(WORK), 32'd0);
    @(negedge HCLK);
    chk("data_htrans", 32'(HTRANS), 32'(2'b00));
    chk("data_work", 32'(WORK), 32'd1);
    wait_idle();
    chk("timer_enable", 32'(en_r), 32'd1);

    // 2: clear count, read it back 10 cycles after the write accept
    issue(1'b1, 30'h4, 32'h0, 1'b1, 32'h0, 0, 1'b0, 3, 1);
    repeat (9) @(posedge HCLK);
    issue(1'b0, 30'h4, 32'h0, 1'b1, 32'd10, 2, 1'b0, 4, 1);
    wait_idle();
    issue(1'b0, 30'h0, 32'h0, 1'b1, 32'h1, 0, 1'b0, 4, 1);
    issue(1'b0, 30'h10, 32'h0, 1'b1, 32'hDEADBEEF, 0, 1'b0, 4, 1);
    wait_idle();
    repeat (2) @(negedge HCLK);
    chk("rdata_hold", rsp_rdata, 32'hDEADBEEF);

    // 3: wait states on a write and a read
    stall_cfg = 5;
    issue(1'b1, 30'h40, 32'hA5A55A5A, 1'b1, 32'h0, 0, 1'b0, 8, 6);
    wait_idle();
    stall_cfg = 2;
    issue(1'b0, 30'h10, 32'h0, 1'b1, 32'hDEADBEEF, 0, 1'b0, 6, 3);
    wait_idle();
    stall_cfg = 0;

    // 4: stuck HREADY aborts after 16 data cycles
    stuck = 1'b1;
    issue(1'b0, 30'h4, 32'h0, 1'b1, 32'h0, 0, 1'b1, 18, 16);
    wait_idle();
    stuck = 1'b0;

    // 5: slave error on a read
    issue(1'b0, 30'h3FFFFFFF, 32'h0, 1'b1, 32'h0, 0, 1'b1, 3, 1);
    wait_idle();
    chk("err_back_idle", 32'(cmd_ready), 32'd1);

    // 6: one-cycle reset during a write data phase
    issue(1'b0, 30'h10, 32'h0, 1'b1, 32'hDEADBEEF, 0, 1'b0, 4, 1);
    wait_idle();
    stall_cfg = 3;
    issue(1'b1, 30'h20, 32'hCAFEF00D, 1'b0, 32'h0, 0, 1'b0, 0, 0);
    @(posedge HCLK); #1;
    chk("pre_reset_work", 32'(WORK), 32'd1);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk_reset_vals("midreset");
    repeat (6) @(negedge HCLK);
    stall_cfg = 0;
    issue(1'b1, 30'h0, 32'h1, 1'b1, 32'h0, 0, 1'b0, 3, 1);
    issue(1'b0, 30'h0, 32'h0, 1'b1, 32'h1, 0, 1'b0, 4, 1);
    wait_idle();

    repeat (5) @(negedge HCLK);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
